// File: rtl/lc3b_types.sv
// Shared LC-3b bus types used by the memory responder and its backing array.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;
    typedef logic [3:0]  lc3b_mem_latency;

    localparam lc3b_mem_latency LC3B_DEFAULT_MEM_LATENCY = 4'd3;

endpackage

// File: rtl/mem_responder_if.sv
// LC-3b memory bus: the CPU side drives requests, the memory side answers with a one-cycle resp.
interface mem_responder_if;
    import lc3b_types::*;

    logic          m_cyc;
    logic          m_stb;
    logic          mem_write;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    lc3b_word      mem_rdata;
    logic          mem_resp;

    modport master (
        output m_cyc, m_stb, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  m_cyc, m_stb, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );

endinterface

// File: rtl/mem_array.sv
// Word array built from one byte-wide RAM per lane, with a registered read port
// whose output register clears on reset and otherwise holds the last read word.
module mem_array
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_BITS-1:0] addr,
    input  lc3b_mem_wmask        we,
    input  logic                 re,
    input  lc3b_word             wdata,
    output lc3b_word             rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_rdata_q;

        always_ff @(posedge clk) begin
            if (we[gi]) begin
                lane_mem[addr] <= wdata[gi*8 +: 8];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_rdata_q <= 8'h00;
            end else if (re) begin
                lane_rdata_q <= lane_mem[addr];
            end
        end

        assign rdata[gi*8 +: 8] = lane_rdata_q;
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts m_cyc/m_stb requests, waits a fixed latency,
// performs the array access on the edge entering ACK and pulses mem_resp for one cycle.
module mem_responder
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = int'(LC3B_DEFAULT_MEM_LATENCY)
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam lc3b_mem_latency COUNT_LOAD =
        (LATENCY > 1) ? lc3b_mem_latency'(LATENCY - 2) : lc3b_mem_latency'(0);

    state_e                 state_q, state_d;
    lc3b_mem_latency        count_q, count_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic                   write_q, write_d;
    lc3b_mem_wmask          be_q, be_d;
    lc3b_word               wdata_q, wdata_d;
    logic                   resp_q, resp_d;

    logic                   req;
    logic [ADDR_BITS-1:0]   req_idx;
    logic                   enter_ack;
    logic                   op_write;
    lc3b_mem_wmask          op_be;
    logic [ADDR_BITS-1:0]   arr_addr;
    lc3b_mem_wmask          arr_we;
    logic                   arr_re;
    lc3b_word               wdata_sel;
    lc3b_word               arr_rdata;
    logic                   unused_addr_bits;

    assign req              = bus.m_cyc && bus.m_stb;
    assign req_idx          = bus.mem_address[ADDR_BITS:1];
    assign unused_addr_bits = ^bus.mem_address;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        write_d   = write_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        resp_d    = 1'b0;
        enter_ack = 1'b0;
        arr_addr  = idx_q;
        op_write  = write_q;
        op_be     = be_q;
        wdata_sel = wdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = req_idx;
                    write_d = bus.mem_write;
                    be_d    = bus.mem_byte_enable;
                    wdata_d = bus.mem_wdata;
                    if (LATENCY == 1) begin
                        // Single-cycle latency: the access uses the live bus values.
                        state_d   = ACK;
                        enter_ack = 1'b1;
                        arr_addr  = req_idx;
                        op_write  = bus.mem_write;
                        op_be     = bus.mem_byte_enable;
                        wdata_sel = bus.mem_wdata;
                    end else begin
                        count_d = COUNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (count_q == '0) begin
                    state_d   = ACK;
                    enter_ack = 1'b1;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        resp_d = enter_ack;
    end

    // Array strobes are gated by rst_n so no access slips through while reset is held.
    assign arr_we = (enter_ack && op_write && rst_n) ? op_be : 2'b00;
    assign arr_re = enter_ack && !op_write && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            be_q    <= 2'b00;
            wdata_q <= 16'h0000;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
        end
    end

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem_array (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (arr_addr),
        .we    (arr_we),
        .re    (arr_re),
        .wdata (wdata_sel),
        .rdata (arr_rdata)
    );

    assign bus.mem_rdata = arr_rdata;
    assign bus.mem_resp  = resp_q;

endmodule
